aes_vector_sequencer: RTL and testbench
=======================================

AES_VECTOR_SEQUENCER -- requirements
Module: aes_vector_sequencer

Interface
REQ-001 Parameter KEY_SIZE, default 128, AES key length in bits; legal values 128, 192 and 256.
REQ-002 Parameter LATENCY, default 10, cycles from DUT input issue to DUT output valid; legal range 1..32.
REQ-003 Parameter SWEEP_BITS, default 128, count of plaintext bit positions toggled per seeded vector; legal range 1..128.
REQ-004 Parameter CNT_W, default 32, width of every statistics counter.
REQ-005 clock  in  1  single clock; all state changes on its posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vec_valid  in  1  test vector present on the vec_* inputs.
REQ-008 vec_ready  out  1  sequencer accepts the vector this cycle.
REQ-009 vec_seeded  in  1  0 = directed vector, 1 = seeded sweep.
REQ-010 vec_last  in  1  final vector of the test run.
REQ-011 vec_plain  in  128  plaintext.
REQ-012 vec_key  in  KEY_SIZE  key.
REQ-013 vec_expect  in  128  expected ciphertext; used only for directed vectors.
REQ-014 dut_plain  out  128  plaintext driven to the encoder.
REQ-015 dut_key  out  KEY_SIZE  key driven to the encoder.
REQ-016 dut_in_valid  out  1  dut_plain and dut_key are a live issue.
REQ-017 dut_out  in  128  encoder ciphertext.
REQ-018 dut_out_valid  in  1  dut_out is valid.
REQ-019 pass_count, fail_count, seeded_count, proto_err_count  out  CNT_W each  statistics counters.
REQ-020 first_fail_idx  out  CNT_W  issue index of the first mismatching vector.
REQ-021 done  out  1  run complete and pipeline drained.

Function
REQ-022 FSM states: IDLE, DIRECT, SWEEP_T, SWEEP_I, SWEEP_F, DRAIN, DONE.
REQ-023 vec_ready is 1 only in IDLE; a vector is accepted when vec_valid and vec_ready are both 1 on the same cycle.
REQ-024 On accept: the vector is latched; vec_seeded=0 goes to DIRECT, vec_seeded=1 goes to SWEEP_T.
REQ-025 DIRECT behaviour:
- issues one cycle: dut_plain=plain, dut_key=key;
- pushes an expected entry {valid=1, expect, index};
- next state is IDLE, or DRAIN if the latched last flag is 1.
REQ-026 SWEEP_T behaviour:
- issues SWEEP_BITS consecutive cycles, i = 0..SWEEP_BITS-1;
- dut_plain = plain XOR (1<<i), dut_key = key;
- pushes an entry with valid=0 (unchecked).
REQ-027 SWEEP_I: same SWEEP_BITS issues as SWEEP_T, but dut_key = bitwise NOT key.
REQ-028 SWEEP_F: issues one cycle with the unmodified plain and key, then goes to IDLE, or DRAIN if last.
REQ-029 A seeded vector therefore issues exactly 2*SWEEP_BITS+1 back-to-back cycles, with no bubbles.
REQ-030 dut_in_valid is 1 exactly on issue cycles; dut_plain and dut_key hold their last values otherwise.
REQ-031 Issue index: a CNT_W counter incremented once per issue cycle; wraps on overflow.
REQ-032 Expected pipeline: shift register of depth LATENCY; each stage holds {issued, checked, expect, index} and advances every cycle.
REQ-033 A bubble enters the pipeline (issued=0) on every cycle with no issue.
REQ-034 Output check, performed every cycle on the pipeline tail:
- dut_out_valid=1, issued=0: proto_err_count increments;
- dut_out_valid=0, issued=1: proto_err_count increments;
- both 1, checked=0: seeded_count increments;
- both 1, checked=1, dut_out equals expect: pass_count increments;
- both 1, checked=1, dut_out differs: fail_count increments, and first_fail_idx captures the tail index only on the first failure.
REQ-035 All counters saturate at all-ones and do not wrap.
REQ-036 DRAIN counts LATENCY cycles with no issue, then moves to DONE; checks continue throughout DRAIN.
REQ-037 DONE: done=1 and the state holds until reset; vec_ready=0.
REQ-038 Simultaneous events in the same cycle: tail check and new issue are independent and both take effect.

Reset
REQ-039 While reset=0 and after its release:
- state=IDLE;
- all pipeline stages are bubbles;
- every counter, first_fail_idx, the issue index, dut_plain and dut_key are 0;
- dut_in_valid=0 and done=0.
REQ-040 Reset asserted mid-sweep or mid-drain aborts the run immediately; no partial counts are retained.

Verification
REQ-041 Directed vector (FIPS-197 C.1: key 000102..0f, plain 00112233..eeff, expect 69c4e0d8..c55a) with a model returning it after LATENCY cycles -> pass_count=1, fail_count=0, done=1 exactly LATENCY+1 cycles after DIRECT.
REQ-042 Same vector with expect bit 0 flipped -> fail_count=1, first_fail_idx=0, pass_count=0.
REQ-043 Seeded vector with SWEEP_BITS=128 -> 257 issue cycles; cycles 1..128 carry key, cycles 129..256 carry ~key; seeded_count=257.
REQ-044 Model emits dut_out_valid one cycle early -> proto_err_count=2, pass_count=0.
REQ-045 Reset dropped at sweep cycle 50, then the directed vector re-applied -> counters restart from 0, pass_count=1.
REQ-046 Directed and seeded vectors alternated with vec_valid held high -> exactly one accept per IDLE visit, and no issue cycle is lost or duplicated.

Source files
------------

// File: rtl/aes_vector_sequencer.sv
// rtl/aes_vector_sequencer.sv - AES encoder test-vector sequencer with expected-result pipeline and statistics
module aes_vector_sequencer #(
  parameter int KEY_SIZE   = 128,
  parameter int LATENCY    = 10,
  parameter int SWEEP_BITS = 128,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic                vec_seeded,
  input  logic                vec_last,
  input  logic [127:0]        vec_plain,
  input  logic [KEY_SIZE-1:0] vec_key,
  input  logic [127:0]        vec_expect,
  output logic [127:0]        dut_plain,
  output logic [KEY_SIZE-1:0] dut_key,
  output logic                dut_in_valid,
  input  logic [127:0]        dut_out,
  input  logic                dut_out_valid,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic [CNT_W-1:0]    seeded_count,
  output logic [CNT_W-1:0]    proto_err_count,
  output logic [CNT_W-1:0]    first_fail_idx,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIRECT, S_SWEEP_T, S_SWEEP_I, S_SWEEP_F, S_DRAIN, S_DONE
  } state_e;

  localparam logic [7:0] SWEEP_LAST = 8'(SWEEP_BITS - 1);
  localparam logic [5:0] DRAIN_LAST = 6'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [127:0]        plain_q, plain_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [127:0]        expect_q, expect_d;
  logic                last_q, last_d;
  logic [7:0]          bit_q, bit_d;
  logic [5:0]          drain_q, drain_d;
  logic [CNT_W-1:0]    issue_idx_q, issue_idx_d;
  logic [127:0]        hold_plain_q, hold_plain_d;
  logic [KEY_SIZE-1:0] hold_key_q, hold_key_d;
  logic [CNT_W-1:0]    pass_q, pass_d, fail_q, fail_d;
  logic [CNT_W-1:0]    seeded_q, seeded_d, proto_q, proto_d;
  logic [CNT_W-1:0]    first_fail_q, first_fail_d;

  logic                pipe_issued_q  [LATENCY];
  logic                pipe_issued_d  [LATENCY];
  logic                pipe_checked_q [LATENCY];
  logic                pipe_checked_d [LATENCY];
  logic [127:0]        pipe_expect_q  [LATENCY];
  logic [127:0]        pipe_expect_d  [LATENCY];
  logic [CNT_W-1:0]    pipe_index_q   [LATENCY];
  logic [CNT_W-1:0]    pipe_index_d   [LATENCY];

  logic                issue;
  logic                issue_checked;
  logic [127:0]        issue_plain;
  logic [KEY_SIZE-1:0] issue_key;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    plain_d       = plain_q;
    key_d         = key_q;
    expect_d      = expect_q;
    last_d        = last_q;
    bit_d         = bit_q;
    drain_d       = drain_q;
    issue         = 1'b0;
    issue_checked = 1'b0;
    issue_plain   = plain_q;
    issue_key     = key_q;

    case (state_q)
      S_IDLE: begin
        bit_d = 8'd0;
        if (vec_valid) begin
          plain_d  = vec_plain;
          key_d    = vec_key;
          expect_d = vec_expect;
          last_d   = vec_last;
          state_d  = vec_seeded ? S_SWEEP_T : S_DIRECT;
        end
      end
      S_DIRECT: begin
        issue         = 1'b1;
        issue_checked = 1'b1;
        drain_d       = 6'd0;
        state_d       = last_q ? S_DRAIN : S_IDLE;
      end
      S_SWEEP_T, S_SWEEP_I: begin
        issue       = 1'b1;
        issue_plain = plain_q ^ (128'd1 << bit_q);
        if (state_q == S_SWEEP_I) issue_key = ~key_q;
        if (bit_q == SWEEP_LAST) begin
          bit_d   = 8'd0;
          state_d = (state_q == S_SWEEP_T) ? S_SWEEP_I : S_SWEEP_F;
        end else begin
          bit_d = bit_q + 8'd1;
        end
      end
      S_SWEEP_F: begin
        issue   = 1'b1;
        drain_d = 6'd0;
        state_d = last_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else drain_d = drain_q + 6'd1;
      end
      default: state_d = S_DONE;
    endcase
  end

  // Issue side: outputs hold their last issued value between issues.
  always_comb begin
    issue_idx_d  = issue ? issue_idx_q + CNT_W'(1) : issue_idx_q;
    hold_plain_d = issue ? issue_plain : hold_plain_q;
    hold_key_d   = issue ? issue_key : hold_key_q;

    pipe_issued_d[0]  = issue;
    pipe_checked_d[0] = issue_checked;
    pipe_expect_d[0]  = expect_q;
    pipe_index_d[0]   = issue_idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_issued_d[i]  = pipe_issued_q[i-1];
      pipe_checked_d[i] = pipe_checked_q[i-1];
      pipe_expect_d[i]  = pipe_expect_q[i-1];
      pipe_index_d[i]   = pipe_index_q[i-1];
    end
  end

  // Tail check runs every cycle, independent of whatever is being issued.
  always_comb begin
    pass_d       = pass_q;
    fail_d       = fail_q;
    seeded_d     = seeded_q;
    proto_d      = proto_q;
    first_fail_d = first_fail_q;
    if (dut_out_valid != pipe_issued_q[LATENCY-1]) begin
      proto_d = sat_inc(proto_q);
    end else if (dut_out_valid) begin
      if (!pipe_checked_q[LATENCY-1]) begin
        seeded_d = sat_inc(seeded_q);
      end else if (dut_out == pipe_expect_q[LATENCY-1]) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (fail_q == '0) first_fail_d = pipe_index_q[LATENCY-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      plain_q      <= '0;
      key_q        <= '0;
      expect_q     <= '0;
      last_q       <= 1'b0;
      bit_q        <= 8'd0;
      drain_q      <= 6'd0;
      issue_idx_q  <= '0;
      hold_plain_q <= '0;
      hold_key_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      seeded_q     <= '0;
      proto_q      <= '0;
      first_fail_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_issued_q[i]  <= 1'b0;
        pipe_checked_q[i] <= 1'b0;
        pipe_expect_q[i]  <= '0;
        pipe_index_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      plain_q      <= plain_d;
      key_q        <= key_d;
      expect_q     <= expect_d;
      last_q       <= last_d;
      bit_q        <= bit_d;
      drain_q      <= drain_d;
      issue_idx_q  <= issue_idx_d;
      hold_plain_q <= hold_plain_d;
      hold_key_q   <= hold_key_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      seeded_q     <= seeded_d;
      proto_q      <= proto_d;
      first_fail_q <= first_fail_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_issued_q[i]  <= pipe_issued_d[i];
        pipe_checked_q[i] <= pipe_checked_d[i];
        pipe_expect_q[i]  <= pipe_expect_d[i];
        pipe_index_q[i]   <= pipe_index_d[i];
      end
    end
  end

  assign vec_ready       = (state_q == S_IDLE);
  assign done            = (state_q == S_DONE);
  assign dut_in_valid    = issue;
  assign dut_plain       = issue ? issue_plain : hold_plain_q;
  assign dut_key         = issue ? issue_key : hold_key_q;
  assign pass_count      = pass_q;
  assign fail_count      = fail_q;
  assign seeded_count    = seeded_q;
  assign proto_err_count = proto_q;
  assign first_fail_idx  = first_fail_q;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// tb/tb_aes_vector_sequencer.sv - directed bench with stand-in encoder and issue-stream scoreboard
module tb_aes_vector_sequencer;
  localparam int KS  = 128;
  localparam int LAT = 10;
  localparam int SB  = 128;
  localparam int CW  = 32;

  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] KA = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] PB = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [127:0] KB = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           vec_valid = 1'b0, vec_seeded = 1'b0, vec_last = 1'b0;
  logic [127:0]   vec_plain = '0, vec_expect = '0;
  logic [KS-1:0]  vec_key = '0;
  logic           vec_ready, dut_in_valid, dut_out_valid, done;
  logic [127:0]   dut_plain, dut_out;
  logic [KS-1:0]  dut_key;
  logic [CW-1:0]  pass_count, fail_count, seeded_count, proto_err_count, first_fail_idx;

  always #5 clk = ~clk;

  aes_vector_sequencer #(.KEY_SIZE(KS), .LATENCY(LAT), .SWEEP_BITS(SB), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_seeded(vec_seeded), .vec_last(vec_last),
    .vec_plain(vec_plain), .vec_key(vec_key), .vec_expect(vec_expect),
    .dut_plain(dut_plain), .dut_key(dut_key), .dut_in_valid(dut_in_valid),
    .dut_out(dut_out), .dut_out_valid(dut_out_valid),
    .pass_count(pass_count), .fail_count(fail_count), .seeded_count(seeded_count),
    .proto_err_count(proto_err_count), .first_fail_idx(first_fail_idx), .done(done)
  );

  // Stand-in encoder: FIPS-197 C.1 answer for the C.1 inputs, a cheap mix otherwise.
  function automatic logic [127:0] enc_f(input logic [127:0] p, input logic [127:0] k);
    if (p == C1_PLAIN && k == C1_KEY) return C1_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
  endfunction

  logic         early_mode = 1'b0;
  logic         enc_v [LAT];
  logic [127:0] enc_d [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        enc_v[i] <= 1'b0;
        enc_d[i] <= '0;
      end
    end else begin
      enc_v[0] <= dut_in_valid;
      enc_d[0] <= enc_f(dut_plain, dut_key);
      for (int i = 1; i < LAT; i++) begin
        enc_v[i] <= enc_v[i-1];
        enc_d[i] <= enc_d[i-1];
      end
    end
  end

  assign dut_out_valid = early_mode ? enc_v[LAT-2] : enc_v[LAT-1];
  assign dut_out       = early_mode ? enc_d[LAT-2] : enc_d[LAT-1];

  int n_checks = 0;
  int n_fails  = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: the exact issue stream each accepted vector must produce,
  // plus the statistics totals it must add up to.
  typedef struct {
    logic [127:0] p;
    logic [127:0] k;
  } iss_t;

  iss_t          exp_q[$];
  int            accepts, n_issue;
  logic [CW-1:0] exp_pass, exp_fail, exp_seeded, exp_first, model_idx;
  bit            first_seen;

  initial begin : compare_proc
    iss_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        accepts = 0; n_issue = 0;
        exp_pass = '0; exp_fail = '0; exp_seeded = '0; exp_first = '0; model_idx = '0;
        first_seen = 1'b0;
      end else begin
        chk("issue_valid", 128'(dut_in_valid), 128'(exp_q.size() != 0));
        if (dut_in_valid && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("issue_plain", dut_plain, e.p);
          chk("issue_key", dut_key, e.k);
        end
        if (dut_in_valid) n_issue++;
        if (vec_valid && vec_ready) begin
          accepts++;
          if (!vec_seeded) begin
            exp_q.push_back('{p: vec_plain, k: vec_key});
            if (vec_expect == enc_f(vec_plain, vec_key)) exp_pass++;
            else begin
              exp_fail++;
              if (!first_seen) exp_first = model_idx;
              first_seen = 1'b1;
            end
            model_idx++;
          end else begin
            for (int i = 0; i < SB; i++) exp_q.push_back('{p: vec_plain ^ (128'd1 << i), k: vec_key});
            for (int i = 0; i < SB; i++) exp_q.push_back('{p: vec_plain ^ (128'd1 << i), k: ~vec_key});
            exp_q.push_back('{p: vec_plain, k: vec_key});
            exp_seeded = exp_seeded + CW'(2 * SB + 1);
            model_idx  = model_idx + CW'(2 * SB + 1);
          end
        end
      end
    end
  end

  task automatic do_reset();
    vec_valid  = 1'b0;
    early_mode = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic seeded, input logic last, input logic [127:0] p,
                      input logic [127:0] k, input logic [127:0] x, input logic hold);
    int w = 0;
    vec_seeded = seeded; vec_last = last; vec_plain = p; vec_key = k; vec_expect = x;
    vec_valid  = 1'b1;
    while (!vec_ready && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!vec_ready) begin
      n_checks++; n_fails++;
      $display("FAIL accept_timeout: got vec_ready=0 expected 1 within 2000 cycles");
    end
    @(posedge clk); #1;
    if (!hold) vec_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_checks++; n_fails++;
      $display("FAIL done_timeout: got done=0 expected 1 within 3000 cycles");
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pass"}, 128'(pass_count), 128'(exp_pass));
    chk({tag, "_fail"}, 128'(fail_count), 128'(exp_fail));
    chk({tag, "_seeded"}, 128'(seeded_count), 128'(exp_seeded));
    chk({tag, "_proto"}, 128'(proto_err_count), 128'd0);
    chk({tag, "_first_fail"}, 128'(first_fail_idx), 128'(exp_first));
    chk({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k, cnt, nk, ni;

    // Reset state
    vec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_valid", 128'(dut_in_valid), 128'd0);
    chk("rst_plain", dut_plain, 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 128'(vec_ready), 128'd1);
    chk("rst_key", dut_key, 128'd0);
    chk("rst_pass", 128'(pass_count), 128'd0);
    chk("rst_proto", 128'(proto_err_count), 128'd0);

    // Directed C.1 vector: pass and done timing
    do_reset();
    send(1'b0, 1'b1, C1_PLAIN, C1_KEY, C1_CT, 1'b0);
    chk("c1_issue_valid", 128'(dut_in_valid), 128'd1);
    wait_done(k);
    chk("c1_done_latency", 128'(k), 128'(LAT + 1));
    chk("c1_pass_lit", 128'(pass_count), 128'd1);
    chk("c1_fail_lit", 128'(fail_count), 128'd0);
    chk("c1_ready_done", 128'(vec_ready), 128'd0);
    check_model("c1");

    // Expect bit 0 flipped: a single failure at index 0
    do_reset();
    send(1'b0, 1'b1, C1_PLAIN, C1_KEY, C1_CT ^ 128'd1, 1'b0);
    wait_done(k);
    chk("bad_fail_lit", 128'(fail_count), 128'd1);
    chk("bad_first_lit", 128'(first_fail_idx), 128'd0);
    chk("bad_pass_lit", 128'(pass_count), 128'd0);
    check_model("bad");

    // Seeded sweep: 257 back-to-back issues, key then ~key then key
    do_reset();
    send(1'b1, 1'b1, C1_PLAIN, C1_KEY, '0, 1'b0);
    cnt = 0; nk = 0; ni = 0;
    while (dut_in_valid && cnt < 400) begin
      if (dut_key == C1_KEY) nk++;
      else if (dut_key == ~C1_KEY) ni++;
      cnt++;
      @(posedge clk); #1;
    end
    chk("sweep_issues", 128'(cnt), 128'd257);
    chk("sweep_key_cycles", 128'(nk), 128'd129);
    chk("sweep_nkey_cycles", 128'(ni), 128'd128);
    chk("sweep_hold_plain", dut_plain, C1_PLAIN);
    chk("sweep_hold_key", dut_key, C1_KEY);
    wait_done(k);
    chk("sweep_seeded_lit", 128'(seeded_count), 128'd257);
    check_model("sweep");

    // Encoder answers one cycle early: two protocol errors, no pass
    do_reset();
    early_mode = 1'b1;
    send(1'b0, 1'b1, C1_PLAIN, C1_KEY, C1_CT, 1'b0);
    wait_done(k);
    chk("early_proto_lit", 128'(proto_err_count), 128'd2);
    chk("early_pass_lit", 128'(pass_count), 128'd0);
    chk("early_fail_lit", 128'(fail_count), 128'd0);

    // Reset at sweep cycle 50, then the directed vector again
    do_reset();
    send(1'b1, 1'b1, C1_PLAIN, C1_KEY, '0, 1'b0);
    repeat (49) begin
      @(posedge clk); #1;
    end
    chk("abort_in_sweep", 128'(dut_in_valid), 128'd1);
    chk("abort_seeded_before", 128'(seeded_count), 128'd39);
    rst_n = 1'b0;
    #1;
    chk("abort_seeded_cleared", 128'(seeded_count), 128'd0);
    chk("abort_in_valid", 128'(dut_in_valid), 128'd0);
    chk("abort_plain", dut_plain, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, 1'b1, C1_PLAIN, C1_KEY, C1_CT, 1'b0);
    wait_done(k);
    chk("abort_pass_lit", 128'(pass_count), 128'd1);
    chk("abort_seeded_lit", 128'(seeded_count), 128'd0);
    check_model("abort");

    // Alternating vectors with vec_valid held high
    do_reset();
    send(1'b0, 1'b0, PA, KA, enc_f(PA, KA), 1'b1);
    send(1'b1, 1'b0, C1_PLAIN, C1_KEY, '0, 1'b1);
    send(1'b0, 1'b0, PB, KB, enc_f(PB, KB) ^ 128'h80, 1'b1);
    send(1'b1, 1'b0, PA, KB, '0, 1'b1);
    send(1'b0, 1'b1, C1_PLAIN, C1_KEY, C1_CT, 1'b0);
    wait_done(k);
    chk("alt_accepts", 128'(accepts), 128'd5);
    chk("alt_issues", 128'(n_issue), 128'd517);
    chk("alt_pass_lit", 128'(pass_count), 128'd2);
    chk("alt_fail_lit", 128'(fail_count), 128'd1);
    chk("alt_seeded_lit", 128'(seeded_count), 128'd514);
    chk("alt_first_lit", 128'(first_fail_idx), 128'd258);
    check_model("alt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
